// File: rtl/alu_op_sequencer_if.sv
// Handshake and ALU-side bundle between the instruction register, the sequencer and the ALU.
// The sequencer connects through the slave modport; its environment uses master.
interface alu_op_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic            instr_valid;
    logic [31:0]     instr;
    logic            instr_ready;
    logic [5:0]      alu_cnt;
    logic [XLEN-1:0] imm;
    logic            b_sel_imm;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;
    logic            done;
    logic [XLEN-1:0] result;
    logic            branch_taken;
    logic            illegal;

    modport slave (
        input  instr_valid, instr, alu_result, alu_zero,
        output instr_ready, alu_cnt, imm, b_sel_imm, done, result, branch_taken, illegal
    );

    modport master (
        output instr_valid, instr, alu_result, alu_zero,
        input  instr_ready, alu_cnt, imm, b_sel_imm, done, result, branch_taken, illegal
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle RV32I decode/sequencing control for the registered 6-bit-coded ALU.
// Holds alu_cnt across EXEC and CAPTURE, then reports result and branch decision with done.
module alu_op_sequencer #(
    parameter int unsigned XLEN     = 32,
    parameter logic [5:0]  IDLE_CNT = 6'b111111
) (
    input logic               clk,
    input logic               rst,
    alu_op_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        EXEC,
        CAPTURE,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     instr_q, instr_d;
    logic [5:0]      alu_cnt_q, alu_cnt_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            b_sel_q, b_sel_d;
    logic            done_q, done_d;
    logic            branch_q, branch_d;
    logic            illegal_q, illegal_d;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [5:0]      dec_cnt;
    logic [XLEN-1:0] dec_imm;
    logic            dec_bsel;
    logic            dec_illegal;
    logic            taken;

    assign opcode = instr_q[6:0];
    assign funct3 = instr_q[14:12];
    assign funct7 = instr_q[31:25];

    always_comb begin
        dec_cnt     = IDLE_CNT;
        dec_imm     = '0;
        dec_bsel    = 1'b1;
        dec_illegal = 1'b0;
        case (opcode)
            7'b0110011: begin
                dec_bsel = 1'b0;
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  dec_cnt = 6'b000000;
                        3'b001:  dec_cnt = 6'b000010;
                        3'b010:  dec_cnt = 6'b000011;
                        3'b011:  dec_cnt = 6'b000100;
                        3'b100:  dec_cnt = 6'b000101;
                        3'b101:  dec_cnt = 6'b000110;
                        3'b110:  dec_cnt = 6'b010011;
                        default: dec_cnt = 6'b010100;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_cnt = 6'b000001;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    dec_cnt = 6'b000111;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            7'b0000011: begin
                dec_imm = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
                case (funct3)
                    3'b000, 3'b100: dec_cnt = 6'b001000;
                    3'b001, 3'b101: dec_cnt = 6'b001001;
                    3'b010:         dec_cnt = 6'b001010;
                    default:        dec_illegal = 1'b1;
                endcase
            end
            7'b0010011: begin
                dec_imm = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
                case (funct3)
                    3'b000: dec_cnt = 6'b001101;
                    3'b010: dec_cnt = 6'b001111;
                    3'b011: dec_cnt = 6'b010000;
                    3'b100: dec_cnt = 6'b010001;
                    3'b110: dec_cnt = 6'b010011;
                    3'b111: dec_cnt = 6'b010100;
                    3'b001: begin
                        dec_imm = {{(XLEN-5){1'b0}}, instr_q[24:20]};
                        if (funct7 == 7'b0000000) dec_cnt = 6'b001110;
                        else                      dec_illegal = 1'b1;
                    end
                    default: begin
                        // Shift amounts only: the srai marker in imm[11:5] never reaches the ALU.
                        dec_imm = {{(XLEN-5){1'b0}}, instr_q[24:20]};
                        if (funct7 == 7'b0000000)      dec_cnt = 6'b010010;
                        else if (funct7 == 7'b0100000) dec_cnt = 6'b000111;
                        else                           dec_illegal = 1'b1;
                    end
                endcase
            end
            7'b0100011: begin
                dec_imm = {{(XLEN-12){instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
                case (funct3)
                    3'b000:  dec_cnt = 6'b010101;
                    3'b001:  dec_cnt = 6'b010110;
                    3'b010:  dec_cnt = 6'b010111;
                    default: dec_illegal = 1'b1;
                endcase
            end
            7'b1100011: begin
                dec_bsel = 1'b0;
                dec_imm  = {{(XLEN-13){instr_q[31]}}, instr_q[31], instr_q[7],
                            instr_q[30:25], instr_q[11:8], 1'b0};
                case (funct3)
                    3'b000:  dec_cnt = 6'b011000;
                    3'b001:  dec_cnt = 6'b011001;
                    3'b100:  dec_cnt = 6'b011010;
                    3'b101:  dec_cnt = 6'b011011;
                    3'b110:  dec_cnt = 6'b011100;
                    3'b111:  dec_cnt = 6'b011101;
                    default: dec_illegal = 1'b1;
                endcase
            end
            7'b0110111: begin
                dec_cnt = 6'b011110;
                dec_imm = {{(XLEN-20){1'b0}}, instr_q[31:12]};
            end
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec_cnt = IDLE_CNT;
        end
    end

    // The ALU's zero flag means "compare true" for the unsigned pair and "not equal/less" otherwise.
    always_comb begin
        taken = 1'b0;
        case (alu_cnt_q)
            6'b011000, 6'b011001, 6'b011010, 6'b011011: taken = ~bus.alu_zero;
            6'b011100, 6'b011101:                       taken = bus.alu_zero;
            default:                                    taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        alu_cnt_d = alu_cnt_q;
        imm_d     = imm_q;
        b_sel_d   = b_sel_q;
        result_d  = result_q;
        branch_d  = branch_q;
        illegal_d = illegal_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.instr_valid) begin
                    instr_d   = bus.instr;
                    illegal_d = 1'b0;
                    state_d   = DECODE;
                end
            end
            DECODE: begin
                imm_d   = dec_imm;
                b_sel_d = dec_bsel;
                if (dec_illegal) begin
                    alu_cnt_d = IDLE_CNT;
                    illegal_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end else begin
                    alu_cnt_d = dec_cnt;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                result_d  = bus.alu_result;
                branch_d  = taken;
                alu_cnt_d = IDLE_CNT;
                done_d    = 1'b1;
                state_d   = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                alu_cnt_d = IDLE_CNT;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            alu_cnt_q <= IDLE_CNT;
            imm_q     <= '0;
            b_sel_q   <= 1'b0;
            result_q  <= '0;
            branch_q  <= 1'b0;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            alu_cnt_q <= alu_cnt_d;
            imm_q     <= imm_d;
            b_sel_q   <= b_sel_d;
            result_q  <= result_d;
            branch_q  <= branch_d;
            illegal_q <= illegal_d;
            done_q    <= done_d;
        end
    end

    assign bus.instr_ready  = (state_q == IDLE);
    assign bus.alu_cnt      = alu_cnt_q;
    assign bus.imm          = imm_q;
    assign bus.b_sel_imm    = b_sel_q;
    assign bus.done         = done_q;
    assign bus.result       = result_q;
    assign bus.branch_taken = branch_q;
    assign bus.illegal      = illegal_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: a vector table of instructions with hand-decoded
// expectations, plus sequences for held instr_valid and reset abort.
`timescale 1ns/1ps
module tb_alu_op_sequencer;
    localparam logic [5:0] IDLE_CNT = 6'b111111;
    localparam int         NUM_VECS = 17;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    alu_op_sequencer_if #(.XLEN(32)) bus ();

    alu_op_sequencer #(
        .XLEN    (32),
        .IDLE_CNT(IDLE_CNT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] aluRes;
        logic        aluZero;
        logic        expIllegal;
        logic [5:0]  expCnt;
        logic        chkImm;
        logic [31:0] expImm;
        logic        expBsel;
        logic        expTaken;
    } vec_t;

    vec_t        vecs [NUM_VECS];
    int          testsRun    = 0;
    int          testsFailed = 0;
    logic [31:0] lastResult  = 32'h0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // One full transaction from an IDLE negedge to the following IDLE negedge.
    task automatic applyStimulus(input int idx);
        vec_t v;
        v = vecs[idx];
        checkOutput($sformatf("vec%0d ready idle", idx), 32'(bus.instr_ready), 32'd1);
        bus.instr_valid = 1'b1;
        bus.instr       = v.instr;
        bus.alu_result  = 32'hDEAD_BEEF;
        bus.alu_zero    = ~v.aluZero;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        checkOutput($sformatf("vec%0d ready decode", idx), 32'(bus.instr_ready), 32'd0);
        checkOutput($sformatf("vec%0d done decode", idx), 32'(bus.done), 32'd0);
        checkOutput($sformatf("vec%0d illegal cleared", idx), 32'(bus.illegal), 32'd0);
        checkOutput($sformatf("vec%0d alu_cnt decode", idx), 32'(bus.alu_cnt), 32'(IDLE_CNT));
        if (v.expIllegal) begin
            @(negedge clk);
            checkOutput($sformatf("vec%0d done illegal", idx), 32'(bus.done), 32'd1);
            checkOutput($sformatf("vec%0d illegal flag", idx), 32'(bus.illegal), 32'd1);
            checkOutput($sformatf("vec%0d alu_cnt illegal", idx), 32'(bus.alu_cnt), 32'(IDLE_CNT));
            checkOutput($sformatf("vec%0d result held", idx), bus.result, lastResult);
        end else begin
            @(negedge clk);
            checkOutput($sformatf("vec%0d alu_cnt exec", idx), 32'(bus.alu_cnt), 32'(v.expCnt));
            checkOutput($sformatf("vec%0d b_sel_imm", idx), 32'(bus.b_sel_imm), 32'(v.expBsel));
            if (v.chkImm) begin
                checkOutput($sformatf("vec%0d imm", idx), bus.imm, v.expImm);
            end
            checkOutput($sformatf("vec%0d done exec", idx), 32'(bus.done), 32'd0);
            @(negedge clk);
            checkOutput($sformatf("vec%0d alu_cnt capture", idx), 32'(bus.alu_cnt), 32'(v.expCnt));
            checkOutput($sformatf("vec%0d done capture", idx), 32'(bus.done), 32'd0);
            bus.alu_result = v.aluRes;
            bus.alu_zero   = v.aluZero;
            @(negedge clk);
            checkOutput($sformatf("vec%0d done", idx), 32'(bus.done), 32'd1);
            checkOutput($sformatf("vec%0d result", idx), bus.result, v.aluRes);
            checkOutput($sformatf("vec%0d branch_taken", idx), 32'(bus.branch_taken), 32'(v.expTaken));
            checkOutput($sformatf("vec%0d illegal", idx), 32'(bus.illegal), 32'd0);
            checkOutput($sformatf("vec%0d alu_cnt done", idx), 32'(bus.alu_cnt), 32'(IDLE_CNT));
            lastResult = v.aluRes;
        end
        @(negedge clk);
        checkOutput($sformatf("vec%0d done after", idx), 32'(bus.done), 32'd0);
        checkOutput($sformatf("vec%0d ready after", idx), 32'(bus.instr_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //          instr         aluRes        zero  ill   cnt        chk   imm           bsel  taken
        vecs[0]  = '{32'h002081B3, 32'h00000005, 1'b0, 1'b0, 6'b000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[1]  = '{32'hFFC08093, 32'h00001234, 1'b0, 1'b0, 6'b001101, 1'b1, 32'hFFFFFFFC, 1'b1, 1'b0};
        vecs[2]  = '{32'h4030D093, 32'hF0000000, 1'b0, 1'b0, 6'b000111, 1'b1, 32'h00000003, 1'b1, 1'b0};
        vecs[3]  = '{32'h00208463, 32'h00000001, 1'b0, 1'b0, 6'b011000, 1'b1, 32'h00000008, 1'b0, 1'b1};
        vecs[4]  = '{32'h00208463, 32'h00000000, 1'b1, 1'b0, 6'b011000, 1'b1, 32'h00000008, 1'b0, 1'b0};
        vecs[5]  = '{32'h0020E463, 32'h00000000, 1'b1, 1'b0, 6'b011100, 1'b1, 32'h00000008, 1'b0, 1'b1};
        vecs[6]  = '{32'hFE209EE3, 32'h00000000, 1'b1, 1'b0, 6'b011001, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b0};
        vecs[7]  = '{32'h12345037, 32'h12345000, 1'b0, 1'b0, 6'b011110, 1'b1, 32'h00012345, 1'b1, 1'b0};
        vecs[8]  = '{32'hFF812083, 32'h00000100, 1'b0, 1'b0, 6'b001010, 1'b1, 32'hFFFFFFF8, 1'b1, 1'b0};
        vecs[9]  = '{32'h0020A623, 32'h00000104, 1'b0, 1'b0, 6'b010111, 1'b1, 32'h0000000C, 1'b1, 1'b0};
        vecs[10] = '{32'h402081B3, 32'hFFFFFFFF, 1'b0, 1'b0, 6'b000001, 1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[11] = '{32'h0000007F, 32'h00000000, 1'b0, 1'b1, 6'b111111, 1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[12] = '{32'h0020E1B3, 32'h000000F0, 1'b0, 1'b0, 6'b010011, 1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[13] = '{32'h402091B3, 32'h00000000, 1'b0, 1'b1, 6'b111111, 1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[14] = '{32'h40309093, 32'h00000000, 1'b0, 1'b1, 6'b111111, 1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[15] = '{32'h0020A463, 32'h00000000, 1'b0, 1'b1, 6'b111111, 1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[16] = '{32'h0050B093, 32'h00000001, 1'b0, 1'b0, 6'b010000, 1'b1, 32'h00000005, 1'b1, 1'b0};

        rst             = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = 32'h0;
        bus.alu_result  = 32'h0;
        bus.alu_zero    = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset alu_cnt", 32'(bus.alu_cnt), 32'(IDLE_CNT));
        checkOutput("reset imm", bus.imm, 32'h0);
        checkOutput("reset b_sel_imm", 32'(bus.b_sel_imm), 32'd0);
        checkOutput("reset done", 32'(bus.done), 32'd0);
        checkOutput("reset result", bus.result, 32'h0);
        checkOutput("reset branch_taken", 32'(bus.branch_taken), 32'd0);
        checkOutput("reset illegal", 32'(bus.illegal), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready after reset", 32'(bus.instr_ready), 32'd1);

        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(i);
        end

        // instr_valid held high across a busy period: the second word must wait for IDLE.
        bus.instr_valid = 1'b1;
        bus.instr       = 32'hFFC08093;
        @(negedge clk);
        bus.instr = 32'h402081B3;
        @(negedge clk);
        checkOutput("held first alu_cnt", 32'(bus.alu_cnt), 32'(6'b001101));
        @(negedge clk);
        bus.alu_result = 32'h00000007;
        @(negedge clk);
        checkOutput("held first done", 32'(bus.done), 32'd1);
        checkOutput("held ready on done", 32'(bus.instr_ready), 32'd0);
        checkOutput("held first result", bus.result, 32'h00000007);
        @(negedge clk);
        checkOutput("held ready idle", 32'(bus.instr_ready), 32'd1);
        checkOutput("held done idle", 32'(bus.done), 32'd0);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        checkOutput("held second accepted", 32'(bus.instr_ready), 32'd0);
        @(negedge clk);
        checkOutput("held second alu_cnt", 32'(bus.alu_cnt), 32'(6'b000001));
        @(negedge clk);
        bus.alu_result = 32'h00000009;
        @(negedge clk);
        checkOutput("held second done", 32'(bus.done), 32'd1);
        checkOutput("held second result", bus.result, 32'h00000009);
        @(negedge clk);

        // Reset during EXEC aborts the instruction without a done pulse.
        bus.instr_valid = 1'b1;
        bus.instr       = 32'h002081B3;
        bus.alu_result  = 32'h00000055;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        checkOutput("abort alu_cnt exec", 32'(bus.alu_cnt), 32'(6'b000000));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort ready", 32'(bus.instr_ready), 32'd1);
        checkOutput("abort alu_cnt", 32'(bus.alu_cnt), 32'(IDLE_CNT));
        checkOutput("abort done", 32'(bus.done), 32'd0);
        checkOutput("abort result", bus.result, 32'h0);
        lastResult = 32'h0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput($sformatf("abort no done %0d", c), 32'(bus.done), 32'd0);
        end
        applyStimulus(0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
